hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stalls,
// EX-stage redirect flushes and data-memory wait freezes, with event counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_load,
    input  logic        ex_redirect,
    input  logic        mem_wait,
    input  logic        cnt_clr,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        stall_all,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_BUBBLE   = 2'b01,
        S_REDIRECT = 2'b10
    } state_t;

    state_t     cur_state;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;
    logic       mem_reg_write;
    logic       mem_load;
    logic       wb_reg_write;
    logic       load_use;

    // A load sitting in MEM has no data yet, so it only forwards once it reaches WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic       m_ld,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (rs == 5'd0)
            return 2'b00;
        if (m_we && !m_ld && (m_rd == rs))
            return 2'b01;
        if (w_we && (w_rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    // BUBBLE must not re-stall; in REDIRECT the ID slot is wrong-path and already flushed.
    always_comb begin
        load_use = (cur_state == S_RUN) && id_valid && ex_load && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    always_comb begin
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        stall_all  = 1'b0;
        if (rst) begin
            if (mem_wait) begin
                stall_all  = 1'b1;
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end else begin
                fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, mem_load, wb_rd, wb_reg_write);
                fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, mem_load, wb_rd, wb_reg_write);
                if (ex_redirect) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
            mem_load      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_reg_write  <= 1'b0;
        end else if (!mem_wait) begin
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_load      <= ex_load;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_RUN;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!mem_wait) begin
                case (cur_state)
                    S_REDIRECT: cur_state <= S_RUN;
                    default: begin
                        if (ex_redirect)
                            cur_state <= S_REDIRECT;
                        else if (load_use)
                            cur_state <= S_BUBBLE;
                        else
                            cur_state <= S_RUN;
                    end
                endcase
            end
            // Clear wins over any increment, even while frozen.
            if (cnt_clr) begin
                stall_cnt <= 16'd0;
                flush_cnt <= 16'd0;
            end else if (!mem_wait) begin
                if (ex_redirect && (flush_cnt != 16'hFFFF))
                    flush_cnt <= flush_cnt + 16'd1;
                if (!ex_redirect && load_use && (stall_cnt != 16'hFFFF))
                    stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver predicts each cycle's outputs from a
// queue-based model of the in-flight writers; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_load, ex_redirect, mem_wait, cnt_clr;
    logic [1:0]  fwd_a, fwd_b, state;
    logic        stall_pc, stall_ifid, flush_ifid, flush_idex, stall_all;
    logic [15:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_load(ex_load),
        .ex_redirect(ex_redirect), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .stall_all(stall_all),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } wr_t;

    logic [42:0] exp_q[$];
    wr_t         hist[$];   // most recent retired-from-EX writer first, at most two kept
    int          m_state, scnt, fcnt;
    int          n_state, n_scnt, n_fcnt;
    bit          n_push;
    wr_t         n_wr;

    function automatic logic [1:0] src(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (hist.size() > 0 && hist[0].we && !hist[0].ld && hist[0].rd == rs) return 2'b01;
        if (hist.size() > 1 && hist[1].we && hist[1].rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0;
        scnt = 0;
        fcnt = 0;
    endtask

    task automatic predict(output logic [42:0] e);
        logic lu;
        logic [1:0] fa, fb;
        logic spc, sif, fif, fid, sall;
        n_state = m_state; n_scnt = scnt; n_fcnt = fcnt; n_push = 0;
        n_wr = '{rd: ex_rd, we: ex_reg_write, ld: ex_load};
        fa = 2'b00; fb = 2'b00; spc = 0; sif = 0; fif = 0; fid = 0; sall = 0;
        if (!rst) begin
            e = '0;
            return;
        end
        lu = (m_state == 0) && id_valid && ex_load && (ex_rd != 0) &&
             (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (mem_wait) begin
            sall = 1; spc = 1; sif = 1;
        end else begin
            fa = src(ex_rs1);
            fb = src(ex_rs2);
            n_push = 1;
            if (ex_redirect) begin
                fif = 1; fid = 1;
                n_fcnt = (fcnt < 65535) ? fcnt + 1 : 65535;
            end else if (lu) begin
                spc = 1; sif = 1; fid = 1;
                n_scnt = (scnt < 65535) ? scnt + 1 : 65535;
            end
            if (m_state == 2) n_state = 0;
            else if (ex_redirect) n_state = 2;
            else if (lu) n_state = 1;
            else n_state = 0;
        end
        if (cnt_clr) begin
            n_scnt = 0;
            n_fcnt = 0;
        end
        e = {fa, fb, spc, sif, fif, fid, sall, 2'(m_state), 16'(scnt), 16'(fcnt)};
    endtask

    task automatic step();
        logic [42:0] e;
        predict(e);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            m_state = n_state; scnt = n_scnt; fcnt = n_fcnt;
            if (n_push) begin
                hist.push_front(n_wr);
                if (hist.size() > 2) void'(hist.pop_back());
            end
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_reg_write = 0; ex_load = 0; ex_redirect = 0; mem_wait = 0; cnt_clr = 0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    task automatic load_use_inputs(input logic [4:0] r);
        idle();
        ex_load = 1; ex_reg_write = 1; ex_rd = r; id_valid = 1; id_rs2 = r;
    endtask

    // Monitor: one expected output vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [42:0] e, got;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {fwd_a, fwd_b, stall_pc, stall_ifid, flush_ifid, flush_idex,
                   stall_all, state, stall_cnt, flush_cnt};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%h exp=%h (fwd/stall/flush/state/stall_cnt/flush_cnt)",
                         $time, got, e);
            end
        end
    end

    initial begin
        idle();
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        step(); step();
        chk("reset_state", 16'(state), 16'd0);
        rst = 1;
        step();

        // MEM forwarding of x5
        ex_rd = 5; ex_reg_write = 1; step();
        idle(); ex_rs1 = 5; step();

        // load-use on x7 via rs2, then consumer sees WB forward
        idle(); cnt_clr = 1; step();
        load_use_inputs(7); step();
        chk("lu_state_bubble", 16'(state), 16'd1);
        chk("lu_stall_cnt", stall_cnt, 16'd1);
        idle(); id_valid = 1; id_rs2 = 7; step();
        chk("lu_state_run", 16'(state), 16'd0);
        idle(); ex_rs2 = 7; step();

        // x0 never stalls or forwards
        idle(); ex_load = 1; ex_reg_write = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; step();
        chk("x0_state", 16'(state), 16'd0);
        chk("x0_stall_cnt", stall_cnt, 16'd1);
        idle(); ex_rs1 = 0; step();

        // redirect beats load-use
        idle(); cnt_clr = 1; step();
        load_use_inputs(7); ex_redirect = 1; step();
        chk("rd_state", 16'(state), 16'd2);
        chk("rd_flush_cnt", flush_cnt, 16'd1);
        chk("rd_stall_cnt", stall_cnt, 16'd0);
        idle(); step();

        // mem_wait freeze during a load-use, stall applied after release
        idle(); cnt_clr = 1; step();
        load_use_inputs(9); mem_wait = 1;
        repeat (3) step();
        chk("mw_state_hold", 16'(state), 16'd0);
        chk("mw_stall_cnt_hold", stall_cnt, 16'd0);
        mem_wait = 0; step();
        chk("mw_state_after", 16'(state), 16'd1);
        chk("mw_stall_cnt_after", stall_cnt, 16'd1);
        idle(); step();

        // asynchronous reset while in BUBBLE
        load_use_inputs(3); step();
        rst = 0; model_reset(); #1;
        chk("arst_state", 16'(state), 16'd0);
        step(); step();
        rst = 1; idle(); step(); step();
        chk("arst_cnt", stall_cnt, 16'd0);

        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 1500; i++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rs1       = 5'($urandom_range(0, 3));
            ex_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_load      = 1'($urandom_range(0, 2) == 0);
            ex_redirect  = 1'($urandom_range(0, 9) == 0);
            mem_wait     = 1'($urandom_range(0, 6) == 0);
            cnt_clr      = 1'($urandom_range(0, 49) == 0);
            step();
        end

        // flush counter saturation and clear priority
        idle(); cnt_clr = 1; step();
        idle(); ex_redirect = 1;
        repeat (65535) step();
        chk("sat_preload", flush_cnt, 16'hFFFF);
        step();
        chk("sat_hold", flush_cnt, 16'hFFFF);
        cnt_clr = 1; step();
        chk("clr_priority", flush_cnt, 16'd0);
        idle(); step();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
